multiplication: RTL and testbench

- Sequential IEEE-754 single-precision multiplier, the inverse-operation companion to the team's sequential `division` unit.
- Uses the same load/enable handshake and the same 32-bit operand/result format, so both units drop into the calculator datapath side by side.
- The mantissa product is built by a radix-2 shift-add loop, one bit per clock.
- Rounding is round-to-nearest-even; subnormals are flushed to zero.

---
 rtl/fp_pkg.sv | 39 +++
 rtl/multiplication_if.sv | 14 +
 rtl/mant_mult_seq.sv | 51 +++++
 rtl/multiplication.sv | 135 +++++++++++++
 tb/tb_multiplication.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision definitions for the sequential
// multiplication and division units.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADED,
    S_MUL,
    S_ROUND,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    C_ZERO,
    C_NORMAL,
    C_INF,
    C_NAN
  } fp_class_t;

  // A zero exponent field is treated as zero: subnormals are flushed.
  function automatic fp_class_t classify(input logic [31:0] x);
    fp_class_t c;
    if (x[30:23] == '0)
      c = C_ZERO;
    else if (x[30:23] == '1)
      c = (x[22:0] == '0) ? C_INF : C_NAN;
    else
      c = C_NORMAL;
    return c;
  endfunction

endpackage

// File: rtl/multiplication_if.sv
// Operand/result bus shared by the calculator's sequential FP units.
// Handshake: while load=1 operands are captured each enabled edge; the
// 1->0 edge of load starts the operation; result is valid while done=1.
interface multiplication_if;
  logic        load;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] result;
  logic        done;
  logic        busy;

  modport master (output load, A, B, input result, done, busy);
  modport slave  (input load, A, B, output result, done, busy);
endinterface

// File: rtl/mant_mult_seq.sv
// Radix-2 shift-add 24x24 mantissa multiplier, one multiplier bit per
// enabled edge, LSB first; finished flags the edge that consumes bit 23.
module mant_mult_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  input  logic [23:0] multiplicand,
  input  logic [23:0] multiplier,
  output logic [47:0] product,
  output logic        finished
);

  logic [47:0] r_mcand;
  logic [23:0] r_mplier;
  logic [47:0] r_acc;
  logic [4:0]  r_count;
  logic        r_active;

  // The multiplicand register is pre-shifted so it always equals
  // multiplicand << counter, avoiding a barrel shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (en) begin
      if (start) begin
        r_mcand  <= {24'b0, multiplicand};
        r_mplier <= multiplier;
        r_acc    <= '0;
        r_count  <= '0;
        r_active <= 1'b1;
      end else if (r_active) begin
        if (r_mplier[0])
          r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_count  <= r_count + 5'd1;
        if (r_count == 5'd23)
          r_active <= 1'b0;
      end
    end
  end

  assign product  = r_acc;
  assign finished = r_active && (r_count == 5'd23);

endmodule

// File: rtl/multiplication.sv
// Sequential IEEE-754 single-precision multiplier: classify, shift-add
// mantissa product, round-to-nearest-even, subnormals flushed to zero.
module multiplication
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  multiplication_if.slave  bus,
  output state_t           o_state
);

  state_t           r_state, w_next;
  logic [31:0]      r_a, r_b, r_result;
  logic             r_sign, r_done;
  logic signed [9:0] r_exp;

  fp_class_t        w_cls_a, w_cls_b;
  logic             w_sign, w_special, w_start, w_finished;
  logic [31:0]      w_special_res, w_round_res;
  logic signed [9:0] w_exp_sum, w_exp_fin;
  logic [47:0]      w_product;
  logic             w_norm, w_guard, w_sticky, w_round_up;
  logic [22:0]      w_frac, w_frac_fin;
  logic [23:0]      w_frac_inc;

  assign w_cls_a   = classify(r_a);
  assign w_cls_b   = classify(r_b);
  assign w_sign    = r_a[31] ^ r_b[31];
  assign w_exp_sum = {2'b00, r_a[30:23]} + {2'b00, r_b[30:23]} - 10'(BIAS);

  always_comb begin
    w_special     = 1'b1;
    w_special_res = '0;
    if (w_cls_a == C_NAN || w_cls_b == C_NAN ||
        (w_cls_a == C_INF && w_cls_b == C_ZERO) ||
        (w_cls_a == C_ZERO && w_cls_b == C_INF))
      w_special_res = QNAN;
    else if (w_cls_a == C_INF || w_cls_b == C_INF)
      w_special_res = POS_INF | {w_sign, 31'b0};
    else if (w_cls_a == C_ZERO || w_cls_b == C_ZERO)
      w_special_res = {w_sign, 31'b0};
    else
      w_special = 1'b0;
  end

  mant_mult_seq u_mant (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .start        (w_start),
    .multiplicand ({1'b1, r_a[22:0]}),
    .multiplier   ({1'b1, r_b[22:0]}),
    .product      (w_product),
    .finished     (w_finished)
  );

  // Product of two [1,2) mantissas lies in [1,4): bit 47 selects the
  // normalisation shift and the position of guard/sticky.
  always_comb begin
    w_norm      = w_product[47];
    w_frac      = w_norm ? w_product[46:24] : w_product[45:23];
    w_guard     = w_norm ? w_product[23]    : w_product[22];
    w_sticky    = w_norm ? |w_product[22:0] : |w_product[21:0];
    w_round_up  = w_guard & (w_sticky | w_frac[0]);
    w_frac_inc  = {1'b0, w_frac} + 24'(w_round_up);
    w_frac_fin  = w_frac_inc[23] ? 23'b0 : w_frac_inc[22:0];
    w_exp_fin   = r_exp + 10'(w_norm) + 10'(w_frac_inc[23]);
    if (w_exp_fin >= 10'sd255)
      w_round_res = {r_sign, 8'hFF, 23'b0};
    else if (w_exp_fin <= 10'sd0)
      w_round_res = {r_sign, 31'b0};
    else
      w_round_res = {r_sign, w_exp_fin[7:0], w_frac_fin};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (en) begin
      if (bus.load)
        w_next = S_LOADED;
      else begin
        case (r_state)
          S_LOADED: w_next = w_special ? S_DONE : S_MUL;
          S_MUL:    if (w_finished) w_next = S_ROUND;
          S_ROUND:  w_next = S_DONE;
          default:  w_next = r_state;
        endcase
      end
    end
  end

  always_comb begin
    bus.busy = (r_state == S_MUL) || (r_state == S_ROUND);
    w_start  = en && !bus.load && (r_state == S_LOADED) && !w_special;
    o_state  = r_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else if (en) begin
      if (bus.load) begin
        r_a      <= bus.A;
        r_b      <= bus.B;
        r_result <= '0;
        r_done   <= 1'b0;
      end else if (r_state == S_LOADED) begin
        r_sign <= w_sign;
        r_exp  <= w_exp_sum;
        if (w_special) begin
          r_result <= w_special_res;
          r_done   <= 1'b1;
        end
      end else if (r_state == S_ROUND) begin
        r_result <= w_round_res;
        r_done   <= 1'b1;
      end
    end
  end

  assign bus.result = r_result;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_multiplication.sv
// Bench for the sequential FP multiplier: directed and random products
// scored through an expected-result queue, plus en/load/rst interference.
module tb_multiplication;
  import fp_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  logic   en;
  state_t dbg_state;

  multiplication_if bus ();

  multiplication dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of run, expected end before 1ms");
    $fatal(1, "watchdog expired");
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: full 48-bit product, normalise by left shift, then RNE.
  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [23:0] m;
    logic        s, g, st;
    int          e;
    s = a[31] ^ b[31];
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) e = e + 1;
    else       p = p << 1;
    m  = {1'b0, p[46:24]};
    g  = p[23];
    st = |p[22:0];
    if (g && (st || m[0])) m = m + 24'd1;
    if (m[23]) begin
      m = '0;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'b0};
    if (e <= 0)   return {s, 31'b0};
    return {s, 8'(e), m[22:0]};
  endfunction

  // driver tasks
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.load = 1'b1;
    bus.A    = a;
    bus.B    = b;
    @(negedge clk);
    bus.load = 1'b0;
    check("load_clr_done", 32'(bus.done), 32'd0);
    check("load_clr_result", bus.result, 32'd0);
  endtask

  task automatic wait_done(input int exp_lat, input int exp_busy, input int freeze_at);
    int          n  = 0;
    int          nb = 0;
    logic [31:0] e  = '0;
    while (!bus.done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.busy) nb++;
      if (freeze_at > 0 && n == freeze_at) en = 1'b0;
      if (freeze_at > 0 && n == freeze_at + 10) en = 1'b1;
    end
    en = 1'b1;
    check("done_seen", 32'(bus.done), 32'd1);
    check("latency", 32'(n), 32'(exp_lat));
    check("busy_cycles", 32'(nb), 32'(exp_busy));
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check("result", bus.result, e);
    repeat (2) @(posedge clk);
    #1;
    check("hold_result", bus.result, e);
    check("hold_done", 32'(bus.done), 32'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    exp_q.push_back(exp);
    start_op(a, b);
    wait_done(lat, (lat > 1) ? lat - 1 : 0, 0);
  endtask

  task automatic run_random(input int lo, input int hi);
    logic [31:0] a, b;
    a = {1'($urandom_range(0, 1)), 8'($urandom_range(lo, hi)), 23'($urandom())};
    b = {1'($urandom_range(0, 1)), 8'($urandom_range(lo, hi)), 23'($urandom())};
    run_op(a, b, model_mul(a, b), 26);
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    bus.load = 1'b0;
    bus.A    = '0;
    bus.B    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", bus.result, 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_stay", 32'(dbg_state), 32'(S_IDLE));

    // directed normal and special products
    run_op(32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 26);
    run_op(32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 26);
    run_op(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 26);
    run_op(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 26);
    run_op(32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 26);
    run_op(32'h7F80_0000, 32'h0000_0000, QNAN, 1);
    run_op(32'h0000_0000, 32'h0080_0000, 32'h0000_0000, 1);
    run_op(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 26);
    run_op(32'h7FC1_2345, 32'h3F80_0000, QNAN, 1);
    run_op(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1);
    run_op(32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 1);
    run_op(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1);
    run_op(32'h3F80_0000, 32'h7F80_0000, POS_INF, 1);

    for (int i = 0; i < 6; i++) run_random(100, 154);
    for (int i = 0; i < 4; i++) run_random(1, 254);

    // en held low for 10 edges mid-MUL stretches latency by 10
    exp_q.push_back(32'h4110_0000);
    start_op(32'h4040_0000, 32'h4040_0000);
    wait_done(36, 35, 5);

    // a new load mid-MUL aborts; only the second product appears
    start_op(32'h4040_0000, 32'h4040_0000);
    repeat (10) @(posedge clk);
    exp_q.push_back(32'hBF80_0000);
    start_op(32'hC000_0000, 32'h3F00_0000);
    wait_done(26, 25, 0);

    // asynchronous reset while DONE and while in MUL
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_done_result", bus.result, 32'd0);
    check("rst_async_done_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start_op(32'h4040_0000, 32'h4040_0000);
    repeat (10) @(posedge clk);
    #1;
    check("busy_pre_rst", 32'(bus.busy), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mul_busy", 32'(bus.busy), 32'd0);
    check("rst_mul_state", 32'(dbg_state), 32'(S_IDLE));
    check("rst_mul_done", 32'(bus.done), 32'd0);
    check("rst_mul_result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 26);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
